// File: rtl/cla_adder_pipe.sv
// -----------------------------------------------------------------------------
// cla_adder_pipe
//
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready
// handshakes on both sides and full backpressure.
//
//   Stage 1 registers the bit propagate/generate vectors, the per-group
//   (4-bit) group-generate/group-propagate terms and the carry into bit 0.
//   Stage 2 resolves the group carries with a two-level lookahead, derives
//   the in-group carries with the 4-bit lookahead equations and registers
//   the result.
//
// Parameters:
//   WIDTH      operand width, multiple of 4 and >= 4 (default 16)
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operands valid            in_ready   operands accepted this cycle
//   a, b       operands                  carry_in   carry into bit 0 (add only)
//   sub        0: a+b+carry_in, 1: a-b
//   out_valid  result valid              out_ready  downstream accepts result
//   sum        result                    carry_out  carry out of the MSB
//                                                   (1 = no borrow on sub)
//
// Optional feature (macro CLA_OVERFLOW_FLAG_EN):
//   overflow   registered signed-overflow flag, carry into MSB ^ carry out
// -----------------------------------------------------------------------------
module cla_adder_pipe #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             carry_in,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out
`ifdef CLA_OVERFLOW_FLAG_EN
   ,
   output logic             overflow
`endif
);

   localparam int NGRP = WIDTH / 4;

   generate
      if ((WIDTH % 4 != 0) || (WIDTH < 4)) begin : g_bad_width
         $error("cla_adder_pipe: WIDTH must be a multiple of 4 and at least 4");
      end
   endgenerate

   // ---------------------------------------------------------------- handshake
   logic s1_v_q, s1_v_d;
   logic s2_v_q, s2_v_d;
   logic s1_adv, s2_adv;

   // Stage 2 can take the stage-1 item if it is empty or draining this cycle;
   // stage 1 can accept if empty or its item moves on. in_ready therefore
   // never depends on in_valid.
   assign s2_adv   = s1_v_q & (~s2_v_q | out_ready);
   assign in_ready = ~s1_v_q | s2_adv;
   assign s1_adv   = in_valid & in_ready;

   // NOTE: every variable assigned in an always_comb gets a default first, so
   // no path through the block leaves it unassigned and no latch is inferred.
   always_comb begin
      s1_v_d = s1_v_q;
      s2_v_d = s2_v_q;
      if (s1_adv)      s1_v_d = 1'b1;
      else if (s2_adv) s1_v_d = 1'b0;
      if (s2_adv)         s2_v_d = 1'b1;
      else if (out_ready) s2_v_d = 1'b0;
   end

   // ------------------------------------------------------------------ stage 1
   logic [WIDTH-1:0] b_eff, p_new, g_new;
   logic [WIDTH-1:0] p_q, p_d, g_q, g_d;
   logic [NGRP-1:0]  gg_q, gg_d, gp_q, gp_d;
   logic             c0_q, c0_d;

   // Subtraction is a + ~b + 1: invert b and force the carry in.
   assign b_eff = sub ? ~b : b;
   assign p_new = a ^ b_eff;
   assign g_new = a & b_eff;

   always_comb begin
      p_d  = p_q;
      g_d  = g_q;
      gg_d = gg_q;
      gp_d = gp_q;
      c0_d = c0_q;
      if (s1_adv) begin
         p_d  = p_new;
         g_d  = g_new;
         c0_d = sub | carry_in;
         for (int k = 0; k < NGRP; k++) begin
            gg_d[k] = g_new[4*k+3]
                    | (p_new[4*k+3] & g_new[4*k+2])
                    | (p_new[4*k+3] & p_new[4*k+2] & g_new[4*k+1])
                    | (p_new[4*k+3] & p_new[4*k+2] & p_new[4*k+1] & g_new[4*k]);
            gp_d[k] = &p_new[4*k +: 4];
         end
      end
   end

   // ------------------------------------------------------------------ stage 2
   logic [NGRP:0]    grp_c;
   logic [WIDTH-1:0] bit_c;

   // Group carries as flat sum-of-products:
   //   C[k+1] = GG[k] | GP[k]GG[k-1] | ... | GP[k..0]c0
   // The running product only builds each term; no carry feeds another.
   always_comb begin
      logic acc;
      logic run;
      grp_c    = '0;
      grp_c[0] = c0_q;
      for (int k = 0; k < NGRP; k++) begin
         acc = gg_q[k];
         run = gp_q[k];
         for (int j = k - 1; j >= 0; j--) begin
            acc = acc | (run & gg_q[j]);
            run = run & gp_q[j];
         end
         grp_c[k+1] = acc | (run & c0_q);
      end
   end

   // In-group carries: 4-bit lookahead seeded with the group carry.
   always_comb begin
      logic acc;
      logic run;
      bit_c = '0;
      for (int k = 0; k < NGRP; k++) begin
         bit_c[4*k] = grp_c[k];
         for (int i = 1; i < 4; i++) begin
            acc = g_q[4*k+i-1];
            run = p_q[4*k+i-1];
            for (int j = i - 2; j >= 0; j--) begin
               acc = acc | (run & g_q[4*k+j]);
               run = run & p_q[4*k+j];
            end
            bit_c[4*k+i] = acc | (run & grp_c[k]);
         end
      end
   end

   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;
`ifdef CLA_OVERFLOW_FLAG_EN
   logic             ovf_q, ovf_d;
`endif

   // Result registers only load on s2_adv, so they hold under a stall.
   always_comb begin
      sum_d  = sum_q;
      cout_d = cout_q;
`ifdef CLA_OVERFLOW_FLAG_EN
      ovf_d  = ovf_q;
`endif
      if (s2_adv) begin
         sum_d  = p_q ^ bit_c;
         cout_d = grp_c[NGRP];
`ifdef CLA_OVERFLOW_FLAG_EN
         ovf_d  = bit_c[WIDTH-1] ^ grp_c[NGRP];
`endif
      end
   end

   // ---------------------------------------------------------------- registers
   // NOTE: datapath registers are reset along with the valids: sum/carry_out
   // must read 0 after reset, and clearing stage 1 keeps it deterministic.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_v_q <= 1'b0;
         s2_v_q <= 1'b0;
         p_q    <= '0;
         g_q    <= '0;
         gg_q   <= '0;
         gp_q   <= '0;
         c0_q   <= 1'b0;
         sum_q  <= '0;
         cout_q <= 1'b0;
`ifdef CLA_OVERFLOW_FLAG_EN
         ovf_q  <= 1'b0;
`endif
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         s1_v_q <= s1_v_d;
         s2_v_q <= s2_v_d;
         p_q    <= p_d;
         g_q    <= g_d;
         gg_q   <= gg_d;
         gp_q   <= gp_d;
         c0_q   <= c0_d;
         sum_q  <= sum_d;
         cout_q <= cout_d;
`ifdef CLA_OVERFLOW_FLAG_EN
         ovf_q  <= ovf_d;
`endif
      end
   end

   assign out_valid = s2_v_q;
   assign sum       = sum_q;
   assign carry_out = cout_q;
`ifdef CLA_OVERFLOW_FLAG_EN
   assign overflow  = ovf_q;
`endif

endmodule
